// File: rtl/latch_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : latch_arbiter_if
//  Description : Requester / shared-latch signal bundle for latch_arbiter.
//                master = requester side, slave = arbiter side.
//  Revision    : 1.0  initial release
// ============================================================================
interface latch_arbiter_if;
    logic [3:0]  req;
    logic [31:0] data_in;
    logic        clear;
    logic        latch_en;
    logic        latch_rst;
    logic [7:0]  latch_d;
    logic [3:0]  ack;
    logic [1:0]  owner;
    logic        busy;

    modport master (
        output req, data_in, clear,
        input  latch_en, latch_rst, latch_d, ack, owner, busy
    );

    modport slave (
        input  req, data_in, clear,
        output latch_en, latch_rst, latch_d, ack, owner, busy
    );
endinterface
`default_nettype wire

// File: rtl/latch_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : latch_arbiter
//  Description : Round-robin arbiter granting four requesters access to one
//                shared transparent 8-bit latch. Sequences setup, enable pulse,
//                data hold and a one-cycle ack; a clear request resets the
//                latch instead. All latch controls are registered so the latch
//                enable never glitches.
//  Revision    : 1.0  initial release
// ============================================================================
module latch_arbiter #(
    parameter int EN_CYCLES   = 1,
    parameter int HOLD_CYCLES = 1
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    latch_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_PULSE = 3'd2,
        S_HOLD  = 3'd3,
        S_ACK   = 3'd4,
        S_CLR   = 3'd5
    } state_t;

    // Counters count down to zero, so each timed state loads its length minus one.
    localparam logic [3:0] c_en_load   = 4'(EN_CYCLES - 1);
    localparam logic [3:0] c_hold_load = (HOLD_CYCLES > 0) ? 4'(HOLD_CYCLES - 1) : 4'd0;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [1:0]  r_ptr;
    logic [1:0]  r_owner;
    logic [7:0]  r_latch_d;
    logic        r_latch_en;
    logic        r_latch_rst;
    logic [3:0]  r_ack;
    logic        r_busy;
    logic        w_grant;
    logic [1:0]  w_winner;
    logic [1:0]  w_idx;

    // Round-robin search: start one past the last served requester, first set bit wins.
    always_comb begin
        w_grant  = 1'b0;
        w_winner = r_ptr;
        w_idx    = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            w_idx = r_ptr + 2'(i);
            if (!w_grant && bus.req[w_idx]) begin
                w_grant  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    // Next-state decode; inputs are only looked at while idle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.clear) begin
                    w_state_nxt = S_CLR;
                end else if (w_grant) begin
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: w_state_nxt = S_PULSE;
            S_PULSE: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = (HOLD_CYCLES == 0) ? S_ACK : S_HOLD;
                end
            end
            S_HOLD: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_ACK;
                end
            end
            S_ACK:   w_state_nxt = S_IDLE;
            S_CLR:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Cycle counter: reloads on every state change, otherwise counts down and stops at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 4'd0;
        end else if (w_state_nxt != r_state) begin
            case (w_state_nxt)
                S_PULSE: r_cnt <= c_en_load;
                S_HOLD:  r_cnt <= c_hold_load;
                default: r_cnt <= 4'd0;
            endcase
        end else if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Capture winner and its data byte at grant; data_in is ignored afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner   <= 2'd0;
            r_latch_d <= 8'h00;
        end else if ((r_state == S_IDLE) && (w_state_nxt == S_SETUP)) begin
            r_owner   <= w_winner;
            r_latch_d <= bus.data_in[{w_winner, 3'b000} +: 8];
        end
    end

    // Priority pointer advances only on completed transactions; reset gives requester 0 first turn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 2'd3;
        end else if (r_state == S_ACK) begin
            r_ptr <= r_owner;
        end
    end

    // Outputs registered from the next state so they align with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_latch_en  <= 1'b0;
            r_latch_rst <= 1'b0;
            r_ack       <= 4'd0;
            r_busy      <= 1'b0;
        end else begin
            r_latch_en  <= (w_state_nxt == S_PULSE);
            r_latch_rst <= (w_state_nxt == S_CLR);
            r_ack       <= (w_state_nxt == S_ACK) ? (4'b0001 << r_owner) : 4'd0;
            r_busy      <= (w_state_nxt != S_IDLE);
        end
    end

    // The shared latch is also cleared for as long as the controller is held in reset.
    assign bus.latch_rst = r_latch_rst | ~rst_n;
    assign bus.latch_en  = r_latch_en;
    assign bus.latch_d   = r_latch_d;
    assign bus.ack       = r_ack;
    assign bus.owner     = r_owner;
    assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_latch_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_latch_arbiter
//  Description : Self-checking bench for latch_arbiter. Two instances run side
//                by side (defaults, and EN_CYCLES=3/HOLD_CYCLES=0) on shared
//                stimulus; a transaction-timeline model predicts every output.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_latch_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] data_in;
    logic        clear;

    always #5 clk = ~clk;

    latch_arbiter_if if0 ();
    latch_arbiter_if if1 ();

    assign if0.req = req;  assign if0.data_in = data_in;  assign if0.clear = clear;
    assign if1.req = req;  assign if1.data_in = data_in;  assign if1.clear = clear;

    latch_arbiter dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    latch_arbiter #(.EN_CYCLES(3), .HOLD_CYCLES(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

    logic       o_en   [2];
    logic       o_rst  [2];
    logic       o_busy [2];
    logic [1:0] o_own  [2];
    logic [3:0] o_ack  [2];
    logic [7:0] o_d    [2];

    assign o_en[0] = if0.latch_en;   assign o_en[1] = if1.latch_en;
    assign o_rst[0] = if0.latch_rst; assign o_rst[1] = if1.latch_rst;
    assign o_busy[0] = if0.busy;     assign o_busy[1] = if1.busy;
    assign o_own[0] = if0.owner;     assign o_own[1] = if1.owner;
    assign o_ack[0] = if0.ack;       assign o_ack[1] = if1.ack;
    assign o_d[0] = if0.latch_d;     assign o_d[1] = if1.latch_d;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: each transaction is a timeline measured from its grant edge.
    int         m_en  [2] = '{1, 3};
    int         m_hold[2] = '{1, 0};
    bit         m_active[2];
    bit         m_clr[2];
    int         m_t[2];
    int         m_ptr[2];
    int         m_owner[2];
    logic [7:0] m_d[2];

    int ack_q[$];
    int exp33[5] = '{0, 1, 2, 3, 0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_active[u] = 1'b0;
            m_clr[u]    = 1'b0;
            m_t[u]      = 0;
            m_ptr[u]    = 3;
            m_owner[u]  = 0;
            m_d[u]      = 8'h00;
        end
    endtask

    task automatic model_edge();
        int w;
        for (int u = 0; u < 2; u++) begin
            if (m_active[u]) begin
                if (m_clr[u]) begin
                    m_active[u] = 1'b0;
                end else begin
                    m_t[u]++;
                    if (m_t[u] == 2 + m_en[u] + m_hold[u]) begin
                        m_active[u] = 1'b0;
                        m_ptr[u]    = m_owner[u];
                    end
                end
            end else if (clear) begin
                m_active[u] = 1'b1;
                m_clr[u]    = 1'b1;
                m_t[u]      = 0;
            end else if (req != 4'd0) begin
                w = -1;
                for (int k = 1; k <= 4; k++) begin
                    if (w < 0 && req[(m_ptr[u] + k) % 4]) w = (m_ptr[u] + k) % 4;
                end
                m_active[u] = 1'b1;
                m_clr[u]    = 1'b0;
                m_t[u]      = 0;
                m_owner[u]  = w;
                m_d[u]      = data_in[8*w +: 8];
            end
        end
    endtask

    task automatic check_all(input string tag);
        bit         tx;
        logic       e_en;
        logic [3:0] e_ack;
        for (int u = 0; u < 2; u++) begin
            tx    = m_active[u] && !m_clr[u];
            e_en  = tx && (m_t[u] >= 1) && (m_t[u] <= m_en[u]);
            e_ack = (tx && m_t[u] == 1 + m_en[u] + m_hold[u]) ? 4'(1 << m_owner[u]) : 4'd0;
            chk($sformatf("%s.u%0d.latch_en", tag, u),  32'(o_en[u]),   32'(e_en));
            chk($sformatf("%s.u%0d.latch_rst", tag, u), 32'(o_rst[u]),  32'(!rst_n || (m_active[u] && m_clr[u])));
            chk($sformatf("%s.u%0d.busy", tag, u),      32'(o_busy[u]), 32'(m_active[u]));
            chk($sformatf("%s.u%0d.owner", tag, u),     32'(o_own[u]),  32'(m_owner[u]));
            chk($sformatf("%s.u%0d.ack", tag, u),       32'(o_ack[u]),  32'(e_ack));
            chk($sformatf("%s.u%0d.latch_d", tag, u),   32'(o_d[u]),    32'(m_d[u]));
            chk($sformatf("%s.u%0d.en_rst_excl", tag, u), 32'(o_en[u] & o_rst[u]), 32'd0);
        end
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        if (rst_n) model_edge(); else model_reset();
        #1;
        if (o_ack[0] != 4'd0) begin
            for (int b = 0; b < 4; b++) if (o_ack[0][b]) ack_q.push_back(b);
        end
        check_all(tag);
    endtask

    task automatic idle(input int n);
        req   = 4'd0;
        clear = 1'b0;
        for (int i = 0; i < n; i++) begin
            data_in = $urandom;
            cycle("idle");
        end
    endtask

    initial begin
        int n0, n1, na;

        // Reset state
        rst_n = 1'b0; req = 4'd0; clear = 1'b0; data_in = 32'd0;
        model_reset();
        #1;
        check_all("reset");
        cycle("reset");
        cycle("reset");
        rst_n = 1'b1;
        idle(2);

        // Single req[2] carrying A5; data_in changes afterwards must not reach latch_d
        req = 4'b0100;
        data_in = {8'h5A, 8'hA5, 16'($urandom)};
        cycle("t32_grant");
        req = 4'd0; n0 = 0; n1 = 0;
        for (int i = 0; i < 8; i++) begin
            data_in = $urandom;
            cycle("t32");
            if (o_en[0]) n0++;
            if (o_en[1]) n1++;
            if (i == 2) begin
                chk("t32_u0_ack",   32'(o_ack[0]), 32'h4);
                chk("t32_u0_d",     32'(o_d[0]),   32'hA5);
                chk("t32_u0_owner", 32'(o_own[0]), 32'd2);
            end
            if (i == 3) begin
                chk("t35_u1_ack", 32'(o_ack[1]), 32'h4);
                chk("t35_u1_d",   32'(o_d[1]),   32'hA5);
            end
        end
        chk("t32_u0_en_width", 32'(n0), 32'd1);
        chk("t35_u1_en_width", 32'(n1), 32'd3);

        // All four requesting after reset: order 0,1,2,3,0
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("t33_rst");
        cycle("t33_rst");
        rst_n = 1'b1;
        ack_q.delete();
        req = 4'hF;
        for (int i = 0; i < 60 && ack_q.size() < 5; i++) begin
            data_in = $urandom;
            cycle("t33");
        end
        chk("t33_ack_count", 32'(ack_q.size()), 32'd5);
        for (int k = 0; k < 5 && k < ack_q.size(); k++)
            chk($sformatf("t33_order%0d", k), 32'(ack_q[k]), 32'(exp33[k]));
        idle(8);

        // Clear wins over req[1]; req[1] served afterwards
        clear = 1'b1; req = 4'b0010;
        cycle("t34_clr");
        chk("t34_latch_rst", 32'(o_rst[0]), 32'd1);
        chk("t34_no_ack",    32'(o_ack[0]), 32'd0);
        clear = 1'b0;
        cycle("t34_idle");
        cycle("t34_grant");
        req = 4'd0; na = 0;
        for (int i = 0; i < 6; i++) begin
            data_in = $urandom;
            cycle("t34");
            if (o_ack[0] == 4'b0010) na++;
        end
        chk("t34_req1_acks", 32'(na), 32'd1);
        idle(8);

        // Reset during PULSE aborts; req[3] served after release
        req = 4'b0001;
        cycle("t36_grant");
        req = 4'd0;
        cycle("t36_pulse");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("t36_abort");
        chk("t36_en_low",   32'(o_en[0]),  32'd0);
        chk("t36_rst_high", 32'(o_rst[0]), 32'd1);
        cycle("t36_hold");
        rst_n = 1'b1;
        req = 4'b1000;
        cycle("t36_grant3");
        req = 4'd0; na = 0; n0 = 0;
        for (int i = 0; i < 8; i++) begin
            data_in = $urandom;
            cycle("t36");
            if (o_ack[0] == 4'b1000) na++;
            if (o_ack[0] == 4'b0001) n0++;
        end
        chk("t36_ack3",    32'(na),       32'd1);
        chk("t36_no_ack0", 32'(n0),       32'd0);
        chk("t36_owner3",  32'(o_own[0]), 32'd3);

        // req[0] dropped during SETUP still completes
        req = 4'b0001;
        cycle("t37_grant");
        req = 4'd0; na = 0;
        for (int i = 0; i < 8; i++) begin
            data_in = $urandom;
            cycle("t37");
            if (o_ack[0] == 4'b0001) na++;
        end
        chk("t37_ack0", 32'(na), 32'd1);

        // Randomized traffic with occasional clears and asynchronous resets
        for (int i = 0; i < 400; i++) begin
            req     = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
            clear   = ($urandom_range(0, 15) == 0);
            data_in = $urandom;
            if ($urandom_range(0, 79) == 0) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                check_all("rnd_rst");
                cycle("rnd_rst");
                rst_n = 1'b1;
            end else begin
                cycle("rnd");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
